// File: rtl/rnd_lfsr_source_pkg.sv
// rnd_lfsr_source_pkg: shared word width, FSM encodings and default LFSR tap table
`ifndef RNDSIZE
`define RNDSIZE 8
`endif
package rnd_lfsr_source_pkg;
    localparam int RNDSIZE_W = `RNDSIZE;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    function automatic logic [31:0] default_taps(input int w);
        return w == 4 ? 32'h0000_000C : w == 8 ? 32'h0000_00B8 :
               w == 16 ? 32'h0000_B400 : w == 32 ? 32'h8020_0003 : 32'h0000_0001;
    endfunction
endpackage

// File: rtl/rnd_lfsr_source_lfsr_step.sv
// lfsr_step: one Fibonacci LFSR shift, parity of (state & taps) enters at bit 0
module lfsr_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] state,
    input  logic [W-1:0] taps,
    output logic [W-1:0] next
);
    assign next = {state[W-2:0], ^(state & taps)};
endmodule

// File: rtl/rnd_lfsr_source.sv
// rnd_lfsr_source: seedable LFSR advancing STEPS shifts per word, seed in while idle, r out via valid/ready
module rnd_lfsr_source
    import rnd_lfsr_source_pkg::*;
#(
    parameter int               RND_W      = RNDSIZE_W,
    parameter logic [RND_W-1:0] TAPS       = {{(RND_W-1){1'b0}}, 1'b1},
    parameter int               STEPS      = RND_W,
    parameter logic [RND_W-1:0] RESET_SEED = {{(RND_W-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             seed_valid,
    input  logic [RND_W-1:0] seed,
    output logic             seed_ready,
    output logic             seed_err,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [RND_W-1:0] r,
    output logic [15:0]      word_cnt
);
    logic [1:0]       fsm;
    logic [7:0]       cnt;
    logic [RND_W-1:0] lfsr;
    logic [RND_W-1:0] nxt;
    lfsr_step #(.W(RND_W)) u_step (.state(lfsr), .taps(TAPS), .next(nxt));
    assign seed_ready = fsm == IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm      <= IDLE;
            cnt      <= '0;
            lfsr     <= RESET_SEED;
            r        <= '0;
            r_valid  <= 1'b0;
            seed_err <= 1'b0;
            word_cnt <= '0;
        end else begin
            seed_err <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (seed_valid) begin
                        lfsr     <= seed == '0 ? RESET_SEED : seed;
                        seed_err <= seed == '0;
                    end
                    if (enable) begin
                        fsm <= RUN;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        fsm <= IDLE;
                        cnt <= '0;
                    end else begin
                        lfsr <= nxt;
                        cnt  <= cnt + 8'd1;
                        if (cnt == 8'(STEPS - 1)) begin
                            r       <= nxt;
                            r_valid <= 1'b1;
                            fsm     <= HOLD;
                            cnt     <= '0;
                        end
                    end
                end
                HOLD: begin
                    if (r_ready) begin
                        r_valid  <= 1'b0;
                        word_cnt <= word_cnt + 16'd1;
                        fsm      <= enable ? RUN : IDLE;
                        cnt      <= '0;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
    a_lfsr_nonzero: assert property (@(posedge clk) disable iff (rst) lfsr != '0);
endmodule

// File: tb/tb_rnd_lfsr_source.sv
// tb_rnd_lfsr_source: randomized and directed checks of two instances (STEPS=1, STEPS=8) against a word-level model
module tb_rnd_lfsr_source;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en[2];
    logic       sv[2];
    logic       rdy[2];
    logic [7:0] seed[2];
    logic       sr[2];
    logic       se[2];
    logic       rv[2];
    logic [7:0] r[2];
    logic [15:0] wc[2];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rnd_lfsr_source #(.RND_W(8), .TAPS(8'hB8), .STEPS(1), .RESET_SEED(8'h01)) u1 (
        .clk(clk), .rst(rst), .enable(en[0]), .seed_valid(sv[0]), .seed(seed[0]),
        .seed_ready(sr[0]), .seed_err(se[0]), .r_valid(rv[0]), .r_ready(rdy[0]),
        .r(r[0]), .word_cnt(wc[0]));

    rnd_lfsr_source #(.RND_W(8), .TAPS(8'hB8), .STEPS(8), .RESET_SEED(8'h01)) u8 (
        .clk(clk), .rst(rst), .enable(en[1]), .seed_valid(sv[1]), .seed(seed[1]),
        .seed_ready(sr[1]), .seed_err(se[1]), .r_valid(rv[1]), .r_ready(rdy[1]),
        .r(r[1]), .word_cnt(wc[1]));

    // Word-level model: running/holding flags plus shifts still owed for the current word.
    typedef struct {
        bit         run;
        bit         have;
        int         left;
        logic [7:0] lf;
        logic [7:0] word;
        bit         serr;
        int         words;
    } mst_t;
    mst_t m[2];

    function automatic logic [7:0] mstep(input logic [7:0] s);
        return {s[6:0], 1'(($countones(s & 8'hB8)) % 2)};
    endfunction

    function automatic mst_t mreset();
        mst_t n;
        n.run = 0; n.have = 0; n.left = 0; n.lf = 8'h01; n.word = 8'h00; n.serr = 0; n.words = 0;
        return n;
    endfunction

    function automatic mst_t mnext(input mst_t s, input int steps, input bit e, input bit v,
                                   input logic [7:0] sd, input bit rd);
        mst_t n = s;
        n.serr = 0;
        if (s.have) begin
            if (rd) begin
                n.have  = 0;
                n.words = (s.words + 1) % 65536;
                n.run   = e;
                n.left  = steps;
            end
        end else if (s.run) begin
            if (!e) n.run = 0;
            else begin
                n.lf   = mstep(s.lf);
                n.left = s.left - 1;
                if (n.left == 0) begin
                    n.word = n.lf;
                    n.have = 1;
                    n.run  = 0;
                end
            end
        end else begin
            if (v) begin
                n.lf   = sd != 8'h00 ? sd : 8'h01;
                n.serr = sd == 8'h00;
            end
            if (e) begin
                n.run  = 1;
                n.left = steps;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m[0] <= mreset();
            m[1] <= mreset();
        end else begin
            m[0] <= mnext(m[0], 1, en[0], sv[0], seed[0], rdy[0]);
            m[1] <= mnext(m[1], 8, en[1], sv[1], seed[1], rdy[1]);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("cyc_r_valid%0d", i), int'(rv[i]), int'(m[i].have));
                chk($sformatf("cyc_r%0d", i), int'(r[i]), int'(m[i].word));
                chk($sformatf("cyc_word_cnt%0d", i), int'(wc[i]), m[i].words);
                chk($sformatf("cyc_seed_ready%0d", i), int'(sr[i]), int'(!m[i].run && !m[i].have));
                chk($sformatf("cyc_seed_err%0d", i), int'(se[i]), int'(m[i].serr));
            end
        end
    end

    task automatic seed_load(input int i, input logic [7:0] v);
        sv[i] = 1'b1;
        seed[i] = v;
        @(negedge clk);
        sv[i] = 1'b0;
    endtask

    task automatic wait_valid(input int i, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rv[i] && n < bound);
        if (!rv[i]) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout%0d: r_valid=0 required 1 within %0d cycles", i, bound);
        end
    endtask

    logic [7:0] bring[4] = '{8'h02, 8'h04, 8'h08, 8'h11};
    logic [7:0] period[255];
    bit         seen[256];

    initial begin
        int n;
        int dups;
        int zeros;
        logic [7:0] r0;
        for (int i = 0; i < 2; i++) begin
            en[i] = 0; sv[i] = 0; rdy[i] = 0; seed[i] = 8'h00;
        end
        #1 rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_r_valid%0d", i), int'(rv[i]), 0);
            chk($sformatf("rst_r%0d", i), int'(r[i]), 0);
            chk($sformatf("rst_word_cnt%0d", i), int'(wc[i]), 0);
            chk($sformatf("rst_seed_ready%0d", i), int'(sr[i]), 1);
            chk($sformatf("rst_seed_err%0d", i), int'(se[i]), 0);
        end
        #2 rst = 1'b0;
        @(negedge clk);
        // bring-up from seed 01, STEPS=1
        seed_load(0, 8'h01);
        en[0] = 1; rdy[0] = 1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(0, 10, n);
            chk($sformatf("bringup_r%0d", k), int'(r[0]), int'(bring[k]));
            chk($sformatf("bringup_cnt%0d", k), int'(wc[0]), k);
        end
        en[0] = 0;
        @(negedge clk);
        chk("bringup_word_cnt", int'(wc[0]), 4);
        chk("bringup_idle", int'(sr[0]), 1);
        // full period
        seed_load(0, 8'h01);
        en[0] = 1; rdy[0] = 1;
        for (int k = 0; k < 255; k++) begin
            wait_valid(0, 10, n);
            period[k] = r[0];
        end
        en[0] = 0;
        @(negedge clk);
        dups = 0; zeros = 0;
        for (int k = 0; k < 256; k++) seen[k] = 0;
        for (int k = 0; k < 255; k++) begin
            if (period[k] == 8'h00) zeros++;
            if (seen[period[k]]) dups++;
            seen[period[k]] = 1;
        end
        chk("period_zero_words", zeros, 0);
        chk("period_repeats", dups, 0);
        chk("period_last", int'(period[254]), 8'h01);
        chk("period_word_cnt", int'(wc[0]), 259);
        // backpressure, enable dropped while holding
        en[0] = 1; rdy[0] = 0;
        wait_valid(0, 10, n);
        r0 = r[0];
        chk("bp_first_word", int'(r0), 8'h02);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_r_valid", int'(rv[0]), 1);
            chk("bp_r_stable", int'(r[0]), int'(r0));
            chk("bp_word_cnt", int'(wc[0]), 259);
            if (c == 2) en[0] = 0;
        end
        rdy[0] = 1;
        @(negedge clk);
        chk("bp_after_valid", int'(rv[0]), 0);
        chk("bp_after_idle", int'(sr[0]), 1);
        chk("bp_after_cnt", int'(wc[0]), 260);
        rdy[0] = 0;
        // zero seed
        seed_load(0, 8'h00);
        chk("zseed_err_pulse", int'(se[0]), 1);
        @(negedge clk);
        chk("zseed_err_clear", int'(se[0]), 0);
        en[0] = 1; rdy[0] = 1;
        wait_valid(0, 10, n);
        chk("zseed_word", int'(r[0]), 8'h02);
        en[0] = 0;
        @(negedge clk);
        // STEPS=8 latency
        seed_load(1, 8'h01);
        en[1] = 1; rdy[1] = 1;
        wait_valid(1, 20, n);
        chk("lat8_cycles", n, 9);
        chk("lat8_word", int'(r[1]), 8'h1C);
        en[1] = 0;
        @(negedge clk);
        // abort after five shifts, resume from the shifted state
        en[1] = 1;
        repeat (6) @(negedge clk);
        en[1] = 0;
        @(negedge clk);
        chk("abort_no_word", int'(rv[1]), 0);
        chk("abort_idle", int'(sr[1]), 1);
        en[1] = 1;
        wait_valid(1, 20, n);
        chk("resume_cycles", n, 9);
        chk("resume_word", int'(r[1]), 8'h70);
        en[1] = 0;
        @(negedge clk);
        // randomized traffic on both instances
        repeat (1500) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                en[i]   = $urandom_range(0, 9) < 7;
                sv[i]   = $urandom_range(0, 3) == 0;
                seed[i] = $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom);
                rdy[i]  = $urandom_range(0, 2) != 0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            en[i] = 0; sv[i] = 0; rdy[i] = 1;
        end
        repeat (3) @(negedge clk);
        rdy[0] = 0; rdy[1] = 0;
        // asynchronous reset while holding a word
        en[0] = 1;
        wait_valid(0, 20, n);
        en[0] = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_r_valid", int'(rv[0]), 0);
        chk("arst_r", int'(r[0]), 0);
        chk("arst_word_cnt", int'(wc[0]), 0);
        chk("arst_word_cnt8", int'(wc[1]), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("arst_idle", int'(sr[0]), 1);
        en[0] = 1; rdy[0] = 1;
        wait_valid(0, 10, n);
        chk("arst_reseed_word", int'(r[0]), 8'h02);
        en[0] = 0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
